vga_timing_gen: RTL and testbench

Parametrised VGA raster controller, successor to the fixed 640x480 controller. Generates sync and blanking from configurable porch/sync/visible timings with selectable sync polarity. Issues pixel read addresses to the frame buffer and accepts data after a configurable read latency. Sits between the frame-buffer RAM and the board VGA pins, and drives frame/line markers for game logic.

---
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-buffer read port.
// Address stage, RD_LAT-deep flag delay line and registered colour/sync outputs.
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CW     = 4,
  parameter int RD_LAT = 1,
  localparam int RW    = $clog2(V_VIS),
  localparam int CLW   = $clog2(H_VIS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [3*CW-1:0] din,
  output logic [RW-1:0]   row,
  output logic [CLW-1:0]  col,
  output logic            rdn,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic            frame_start,
  output logic            line_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_END  = HW'(H_VIS);
  localparam logic [VW-1:0] V_END  = VW'(V_VIS);
  localparam logic [HW-1:0] HS_LO  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_LO  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_HI  = VW'(V_VIS + V_FP + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          vis;
  logic          hsa;
  logic          vsa;

  // flags per stage: {visible, hs-active, vs-active}
  logic [2:0]    dly [RD_LAT];
  logic [2:0]    tap;

  assign vis = (h < H_END) && (v < V_END);
  assign hsa = (h >= HS_LO) && (h < HS_HI);
  assign vsa = (v >= VS_LO) && (v < VS_HI);
  assign tap = dly[RD_LAT-1];

  // Raster position: h runs every enabled cycle, v steps on h wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Address stage: read request plus frame/line markers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      rdn         <= 1'b1;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (en) begin
      rdn         <= ~vis;
      row         <= vis ? v[RW-1:0] : '0;
      col         <= vis ? h[CLW-1:0] : '0;
      frame_start <= (h == '0) && (v == '0);
      line_start  <= (h == '0) && (v < V_END);
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

  // Flag delay line; entry 0 is captured alongside the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) dly[i] <= '0;
    end else if (en) begin
      dly[0] <= {vis, hsa, vsa};
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // Output stage: latch returning pixel data with aligned sync/blank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r  <= '0;
      g  <= '0;
      b  <= '0;
      de <= 1'b0;
      hs <= ~HS_POL;
      vs <= ~VS_POL;
    end else if (en) begin
      de <= tap[2];
      r  <= tap[2] ? din[CW-1:0]      : '0;
      g  <= tap[2] ? din[2*CW-1:CW]   : '0;
      b  <= tap[2] ? din[3*CW-1:2*CW] : '0;
      hs <= tap[1] ? HS_POL : ~HS_POL;
      vs <= tap[0] ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster.
// Frame-position model plus hand-computed literal expectations.
module tb_vga_timing_gen;

  localparam int HV  = 10;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 2;
  localparam int VV  = 6;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b0;
  localparam int LAT = 2;
  localparam int HT  = HV + HFP + HSW + HBP;
  localparam int VT  = VV + VFP + VSW + VBP;
  localparam int FRM = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [11:0] din;
  logic [11:0] ram_q = '0;
  logic [2:0]  row;
  logic [3:0]  col;
  logic        rdn, hs, vs, de, frame_start, line_start;
  logic [3:0]  r, g, b;

  vga_timing_gen #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HP), .VS_POL(VP), .CW(4), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .row(row), .col(col), .rdn(rdn),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pix(input int rr, input int cc);
    return {4'(cc), 4'(rr), 4'(rr + cc)};
  endfunction

  // Frame buffer with two-cycle read latency (one register after the address)
  always @(posedge clk) if (en) ram_q <= pix(int'(row), int'(col));
  assign din = ram_q;

  // Expected outputs after n enabled edges since reset
  function automatic logic [24:0] model(input int n, input bit pulse);
    bit e_rdn = 1'b1;
    int e_row = 0, e_col = 0;
    bit e_fs = 1'b0, e_ls = 1'b0, e_de = 1'b0;
    bit e_hs = !HP, e_vs = !VP;
    int e_r = 0, e_g = 0, e_b = 0;
    int p, hh, vv;
    if (n >= 1) begin
      p  = (n - 1) % FRM;
      hh = p % HT;
      vv = p / HT;
      if (hh < HV && vv < VV) begin
        e_rdn = 1'b0;
        e_row = vv;
        e_col = hh;
      end
      e_fs = pulse && hh == 0 && vv == 0;
      e_ls = pulse && hh == 0 && vv < VV;
    end
    if (n - 1 - LAT >= 0) begin
      p  = (n - 1 - LAT) % FRM;
      hh = p % HT;
      vv = p / HT;
      e_de = hh < HV && vv < VV;
      e_hs = (hh >= HV + HFP && hh < HV + HFP + HSW) ? HP : !HP;
      e_vs = (vv >= VV + VFP && vv < VV + VFP + VSW) ? VP : !VP;
      if (e_de) begin
        e_r = (vv + hh) % 16;
        e_g = vv;
        e_b = hh;
      end
    end
    return {e_rdn, 3'(e_row), 4'(e_col), e_fs, e_ls, e_de, e_hs, e_vs,
            4'(e_r), 4'(e_g), 4'(e_b)};
  endfunction

  logic [24:0] act;
  logic [24:0] exp_v;
  assign act = {rdn, row, col, frame_start, line_start, de, hs, vs, r, g, b};

  int checks = 0;
  int errors = 0;
  int n = 0;
  int cyc = 0;
  int phase = 0;
  int c_de = 0, c_hs = 0, c_vs = 0, c_ls = 0, c_fs = 0;
  int last_fs = -1;
  bit en_s, rst_s;

  task automatic lit(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Compare process: model every cycle, literals at known points
  always begin
    @(posedge clk);
    en_s  = en;
    rst_s = rst;
    cyc++;
    #1;
    if (rst_s) n = 0;
    else if (en_s) n++;
    exp_v = model(n, en_s && !rst_s);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL model cyc=%0d n=%0d got %h expected %h",
               cyc, n, act, exp_v);
    end
    if (phase == 0 && rst_s)
      lit("reset_idle", 32'({rdn, row, col, de, hs, vs, r, g, b}),
          32'({1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h000}));
    if (phase == 1) begin
      if (n == 1)
        lit("first_edge", 32'({frame_start, line_start, rdn, col}),
            32'({1'b1, 1'b1, 1'b0, 4'd0}));
      if (n == 14) lit("hs_before_sync", 32'(hs), 32'(1'b0));
      if (n == 15) lit("hs_first_sync", 32'(hs), 32'(1'b1));
      if (n == 59)
        lit("pixel_r3_c5", 32'({de, r, g, b}),
            32'({1'b1, 4'd8, 4'd3, 4'd5}));
      if (n >= LAT + 1 && n <= LAT + FRM) begin
        c_de += int'(de);
        c_hs += int'(hs);
        c_vs += int'(!vs);
      end
      if (n == LAT + FRM) begin
        lit("de_per_frame", 32'(c_de), 32'(60));
        lit("hs_per_frame", 32'(c_hs), 32'(30));
        lit("vs_per_frame", 32'(c_vs), 32'(34));
      end
      if (n >= 1 && n <= FRM) c_ls += int'(line_start);
      if (n == FRM) lit("ls_per_frame", 32'(c_ls), 32'(6));
      if (n >= 1 && n <= 2 * FRM) c_fs += int'(frame_start);
      if (n == 2 * FRM) lit("fs_two_frames", 32'(c_fs), 32'(2));
    end
    if (phase == 2 && frame_start) begin
      if (last_fs >= 0)
        lit("fs_period_gated", 32'(cyc - last_fs), 32'(2 * FRM));
      last_fs = cyc;
    end
    if (phase == 4 && n == 1)
      lit("restart_fs", 32'({frame_start, rdn, row, col}),
          32'({1'b1, 1'b0, 3'd0, 4'd0}));
    @(negedge clk);
    if (phase == 3 && rst)
      lit("async_reset", 32'({rdn, de, hs, vs, frame_start, line_start, r, g, b}),
          32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000}));
  end

  bit found;

  initial begin
    repeat (5) @(negedge clk);
    rst   = 1'b0;
    en    = 1'b1;
    phase = 1;
    repeat (2 * FRM + 20) @(negedge clk);
    phase = 2;
    for (int i = 0; i < 4 * FRM + 80; i++) begin
      @(negedge clk);
      en = ~en;
    end
    phase = 5;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      en = (i % 3) != 0;
    end
    @(negedge clk);
    en    = 1'b1;
    phase = 3;
    found = 1'b0;
    for (int i = 0; i < 2 * FRM && !found; i++) begin
      @(posedge clk);
      #3;
      if (n >= 1 && (n - 1) % FRM == 3 * HT + 7) begin
        rst   = 1'b1;
        found = 1'b1;
      end
    end
    if (!found) begin
      $display("FAIL midframe_wait: got no position expected v=3 h=7");
      $fatal(1, "timeout");
    end
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    phase = 4;
    repeat (200) @(negedge clk);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
